// File: rtl/cuber_pkg.sv
// Shared definitions for the iterative cube unit: FSM encoding, default
// operand width and width-derivation helpers.
package cuber_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int OUT_W         = 3 * DEFAULT_WIDTH;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        CU   = 2'd2
    } state_t;

    // Result width for a given operand width.
    function automatic int out_width(input int w);
        return 3 * w;
    endfunction

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/cuber_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally adds the multiplicand to the
// accumulator. This is the only arithmetic adder in the cube unit.
module shift_add_step #(
    parameter int W = 24
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] mcand,
    input  logic         mplier_lsb,
    output logic [W-1:0] acc_next
);

    // Add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        acc_next = acc + (mplier_lsb ? mcand : '0);
    end

endmodule

// File: rtl/cuber.sv
// Iterative integer cube unit, y_out = x_in^3, computed as x*x then (x*x)*x
// with one shift-add partial product per clock (2*WIDTH cycles per result).
// Optional feature macro: CUBER_FASTPATH_EN -- operands 0 and 1 finish after
// a single busy cycle instead of the full iteration sequence.
module cuber
    import cuber_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x_in,
    output logic [3*WIDTH-1:0]   y_out,
    output logic                 busy_o
);

    localparam int OW = out_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state, state_n;
    logic [WIDTH-1:0] x_r, x_r_n;
    logic [OW-1:0]    acc, acc_n;
    logic [OW-1:0]    mcand, mcand_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [OW-1:0]    y_n;
    logic             busy_n;
    logic [OW-1:0]    acc_next;

    // Single shared adder for both the squaring and the cubing pass.
    shift_add_step #(.W(OW)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier_lsb (mplier[0]),
        .acc_next   (acc_next)
    );

    // Next-state and datapath decode for the IDLE -> SQ -> CU sequence.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_n  = state;
        x_r_n    = x_r;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        cnt_n    = cnt;
        y_n      = y_out;
        busy_n   = busy_o;

        unique case (state)
            IDLE: begin
                if (start) begin
                    x_r_n    = x_in;
                    acc_n    = '0;
                    mcand_n  = OW'(x_in);
                    mplier_n = x_in;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = SQ;
`ifdef CUBER_FASTPATH_EN
                    // 0 and 1 are their own cubes: jump straight to the final
                    // CU step, where acc(0) + (x[0] ? x : 0) yields x itself.
                    if (x_in[WIDTH-1:1] == '0) begin
                        cnt_n   = LAST;
                        state_n = CU;
                    end
`endif
                end
            end

            SQ, CU: begin
                acc_n    = acc_next;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + 1'b1;
                if (cnt == LAST) begin
                    if (state == SQ) begin
                        // Square complete: it becomes the multiplicand of the
                        // second pass, multiplied again by the stored operand.
                        mcand_n  = acc_next;
                        mplier_n = x_r;
                        acc_n    = '0;
                        cnt_n    = '0;
                        state_n  = CU;
                    end else begin
                        y_n     = acc_next;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            // NOTE: reset clears every register, so an aborted computation
            // leaves nothing behind that could leak into the next one.
            state  <= IDLE;
            x_r    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            y_out  <= '0;
            busy_o <= 1'b0;
        end else begin
            state  <= state_n;
            x_r    <= x_r_n;
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            cnt    <= cnt_n;
            y_out  <= y_n;
            busy_o <= busy_n;
        end
    end

endmodule
